register_bank: RTL and testbench
================================

# register_bank

Parametrised multi-entry register bank, the next generation of the single 16-bit load register. It holds DEPTH words of WIDTH bits with per-entry valid bits. It has one synchronous write port, two independent registered read ports and a one-cycle bulk clear. It sits beside the CPU datapath as a general-purpose register file and scratch store for the A/D-style registers and future extensions.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden

- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; clears all storage and outputs
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- clr  input  1  bulk clear: zero all entries and valid bits
- re_a  input  1  read enable, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  WIDTH  read data, port A (registered)
- rhit_a  output  1  entry valid at time of read, port A (registered)
- re_b, raddr_b, rdata_b, rhit_b: identical to port A, independent

## Operation
- State: mem[DEPTH] of WIDTH bits, vld[DEPTH] of 1 bit, output registers rdata_a/b, rhit_a/b.
- Priority at each rising edge: reset > clr > we.
- reset=1: mem, vld, rdata_*, rhit_* all 0. All other inputs are ignored that cycle.
- clr=1 (reset=0): mem and vld all 0. A coincident write is dropped. Read ports still sample (see bypass rules).
- we=1 (reset=0, clr=0): mem[waddr] <= wdata and vld[waddr] <= 1. Other entries are unchanged.
- Read port X with re_x=1: rdata_x <= mem[raddr_x] and rhit_x <= vld[raddr_x]. Invalid entries always read as data 0, hit 0.
- re_x=0: rdata_x and rhit_x hold their previous values.
- The two read ports are fully independent. Both may address the same entry, including the write address.
- No illegal addresses exist, because DEPTH is a power of two.

## Timing
- Write latency 1: data is visible to a read issued on the cycle after the write edge.
- Read latency 1: the address is sampled at edge N and rdata/rhit are valid after edge N until the next enabled read.
- Read of waddr in the same cycle as a write: returns pre-write contents (old data, old hit). This changes only under BYPASS_EN.
- Read in the same cycle as clr: returns pre-clear contents. This changes only under BYPASS_EN.
- Reset mid-stream: the next cycle starts clean, with outputs 0 and all entries invalid. A read issued on the reset cycle is discarded.
- No combinational path from any input to any output.

## Configuration
- Macro: REGISTER_BANK_BYPASS_EN.
- Defined: a read returns the post-edge state (write-first).
  - Read of waddr with we=1, clr=0: returns wdata, hit 1.
  - Read with clr=1: returns data 0, hit 0.
  - Bypass is applied per port independently.
- Undefined: read-first as in Timing. No bypass muxes are built.
- reset behaviour is identical in both builds.

## Structure
- No package. The derived address width stays local; the bank has no shared typedefs.
- Natural sub-module: reg_bank_read_port. It contains the registered read mux plus optional bypass and is instantiated twice. Storage and write/clear logic stay in the top module.

## Test plan
- Reset then read: assert reset, then read addr 3 on both ports. Required: rdata_a=rdata_b=0, rhit_a=rhit_b=0.
- Write/read back: write 0xBEEF to addr 5, next cycle read addr 5 on A and addr 4 on B. Required: A=0xBEEF/hit 1, B=0/hit 0.
- Same-cycle collision: addr 2 holds 0x1111; write 0x2222 to addr 2 while A reads addr 2. Required: A=0x1111 without the macro, 0x2222 with it. A read on the next cycle returns 0x2222 in both builds.
- Clear priority: fill all 8 entries, then assert clr with we=1 to addr 0 (0xAAAA). Required: every subsequent read returns 0/hit 0 and the write is lost.
- Hold on disable: read addr 1 (0x00FF), then deassert re_a for 3 cycles while changing raddr_a and writing addr 1. Required: rdata_a stays 0x00FF and rhit_a stays 1.
- Mid-stream reset: after writes to addrs 0..7, assert reset coincident with we and re_a. Required: next-cycle outputs are 0 and all subsequent reads return hit 0.

Source files
------------

// File: rtl/reg_bank_read_port.sv
// reg_bank_read_port: registered read mux over the bank storage; holds its output while re is low.
// With REGISTER_BANK_BYPASS_EN defined, the same-edge write/clear is forwarded (write-first).
module reg_bank_read_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_re,
  input  logic [ADDR_W-1:0]            i_raddr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  i_mem,
  input  logic [DEPTH-1:0]             i_vld,
`ifdef REGISTER_BANK_BYPASS_EN
  input  logic                         i_we,
  input  logic [ADDR_W-1:0]            i_waddr,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_clr,
`endif
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_rhit
);
  logic             w_hit;
  logic [WIDTH-1:0] w_data;
`ifdef REGISTER_BANK_BYPASS_EN
  logic w_fwd;
  always_comb begin
    w_fwd  = i_we && (i_waddr == i_raddr);
    w_hit  = i_clr ? 1'b0 : (w_fwd ? 1'b1 : i_vld[i_raddr]);
    w_data = i_clr ? '0 : (w_fwd ? i_wdata : (i_vld[i_raddr] ? i_mem[i_raddr] : '0));
  end
`else
  always_comb begin
    w_hit  = i_vld[i_raddr];
    w_data = w_hit ? i_mem[i_raddr] : '0;
  end
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      o_rdata <= '0;
      o_rhit  <= 1'b0;
    end else if (i_re) begin
      o_rdata <= w_data;
      o_rhit  <= w_hit;
    end
  end
endmodule

// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH register file with valid bits, one write port, two registered read ports, bulk clear.
// Define REGISTER_BANK_BYPASS_EN for write-first reads; the default build is read-first.
module register_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              clr,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rhit_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rhit_b
);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            r_vld;
  // Clear zeroes data as well as valid so stale words never leak out.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      r_mem <= '0;
      r_vld <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
      r_vld[waddr] <= 1'b1;
    end
  end
  reg_bank_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_a (
    .clock   (clock),
    .reset   (reset),
    .i_re    (re_a),
    .i_raddr (raddr_a),
    .i_mem   (r_mem),
    .i_vld   (r_vld),
`ifdef REGISTER_BANK_BYPASS_EN
    .i_we    (we),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_clr   (clr),
`endif
    .o_rdata (rdata_a),
    .o_rhit  (rhit_a)
  );
  reg_bank_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_b (
    .clock   (clock),
    .reset   (reset),
    .i_re    (re_b),
    .i_raddr (raddr_b),
    .i_mem   (r_mem),
    .i_vld   (r_vld),
`ifdef REGISTER_BANK_BYPASS_EN
    .i_we    (we),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_clr   (clr),
`endif
    .o_rdata (rdata_b),
    .o_rhit  (rhit_b)
  );
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed scenarios plus randomized traffic checked against an array-based reference model.
module tb_register_bank;
  logic        clock = 1'b0;
  logic        reset, we, clr, re_a, re_b;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata;
  logic [15:0] rdata_a, rdata_b;
  logic        rhit_a, rhit_b;
  logic [15:0] m [8];
  bit          v [8];
  logic [15:0] ead, ebd;
  logic        eah, ebh;
  int          tests = 0;
  int          fails = 0;

  register_bank dut (
    .clock(clock), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rhit_a(rhit_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rhit_b(rhit_b)
  );

  always #5 clock = ~clock;

  // Apply one cycle of inputs, advance the model by the bank's rules, sample 1ns after the edge.
  task automatic cycle(input logic rst, input logic c, input logic w, input logic [2:0] wa,
                       input logic [15:0] wd, input logic ae, input logic [2:0] aa,
                       input logic be, input logic [2:0] ba);
    logic [15:0] pm [8];
    bit          pv [8];
    reset = rst; clr = c; we = w; waddr = wa; wdata = wd;
    re_a = ae; raddr_a = aa; re_b = be; raddr_b = ba;
    @(posedge clock);
    pm = m; pv = v;
    if (rst || c) begin
      for (int i = 0; i < 8; i++) begin pm[i] = '0; pv[i] = 0; end
    end else if (w) begin
      pm[wa] = wd; pv[wa] = 1;
    end
    if (rst) begin
      ead = '0; eah = 0; ebd = '0; ebh = 0;
    end else begin
`ifdef REGISTER_BANK_BYPASS_EN
      if (ae) begin ead = pv[aa] ? pm[aa] : '0; eah = pv[aa]; end
      if (be) begin ebd = pv[ba] ? pm[ba] : '0; ebh = pv[ba]; end
`else
      if (ae) begin ead = v[aa] ? m[aa] : '0; eah = v[aa]; end
      if (be) begin ebd = v[ba] ? m[ba] : '0; ebh = v[ba]; end
`endif
    end
    m = pm; v = pv;
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, 3'd0);
  endtask

  task automatic test_reset();
    cycle(1, 0, 1, 3'd3, 16'h1234, 1, 3'd3, 1, 3'd3);
    tests++;
    if ({rdata_a, rhit_a, rdata_b, rhit_b} !== 34'h0) begin
      fails++; $display("FAIL reset_outputs got a=%h/%b b=%h/%b want 0/0", rdata_a, rhit_a, rdata_b, rhit_b);
    end
    cycle(0, 0, 0, 3'd0, 16'h0, 1, 3'd3, 1, 3'd3);
    tests++;
    if ({rdata_a, rhit_a, rdata_b, rhit_b} !== 34'h0) begin
      fails++; $display("FAIL reset_read got a=%h/%b b=%h/%b want 0/0", rdata_a, rhit_a, rdata_b, rhit_b);
    end
  endtask

  task automatic test_write_read();
    cycle(0, 0, 1, 3'd5, 16'hBEEF, 0, 3'd0, 0, 3'd0);
    cycle(0, 0, 0, 3'd0, 16'h0, 1, 3'd5, 1, 3'd4);
    tests++;
    if ({rdata_a, rhit_a, rdata_b, rhit_b} !== {16'hBEEF, 1'b1, 16'h0, 1'b0}) begin
      fails++; $display("FAIL write_read got a=%h/%b b=%h/%b want a=beef/1 b=0/0", rdata_a, rhit_a, rdata_b, rhit_b);
    end
  endtask

  task automatic test_collision();
    cycle(0, 0, 1, 3'd2, 16'h1111, 0, 3'd0, 0, 3'd0);
    cycle(0, 0, 1, 3'd2, 16'h2222, 1, 3'd2, 1, 3'd2);
    tests++;
`ifdef REGISTER_BANK_BYPASS_EN
    if ({rdata_a, rhit_a, rdata_b} !== {16'h2222, 1'b1, 16'h2222}) begin
      fails++; $display("FAIL collision got a=%h/%b b=%h want 2222/1 2222", rdata_a, rhit_a, rdata_b);
    end
`else
    if ({rdata_a, rhit_a, rdata_b} !== {16'h1111, 1'b1, 16'h1111}) begin
      fails++; $display("FAIL collision got a=%h/%b b=%h want 1111/1 1111", rdata_a, rhit_a, rdata_b);
    end
`endif
    cycle(0, 0, 0, 3'd0, 16'h0, 1, 3'd2, 0, 3'd0);
    tests++;
    if ({rdata_a, rhit_a} !== {16'h2222, 1'b1}) begin
      fails++; $display("FAIL collision_next got %h/%b want 2222/1", rdata_a, rhit_a);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 3'(i), 16'($urandom) | 16'h1, 0, 3'd0, 0, 3'd0);
    cycle(0, 1, 1, 3'd0, 16'hAAAA, 1, 3'd0, 1, 3'd7);
    tests++;
    if ({rdata_a, rhit_a, rdata_b, rhit_b} !== {ead, eah, ebd, ebh}) begin
      fails++; $display("FAIL clear_cycle got a=%h/%b b=%h/%b want a=%h/%b b=%h/%b",
                        rdata_a, rhit_a, rdata_b, rhit_b, ead, eah, ebd, ebh);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 3'd0, 16'h0, 1, 3'(i), 1, 3'(7 - i));
      tests++;
      if ({rdata_a, rhit_a, rdata_b, rhit_b} !== 34'h0) begin
        fails++; $display("FAIL clear_after addr=%0d got a=%h/%b b=%h/%b want 0/0", i, rdata_a, rhit_a, rdata_b, rhit_b);
      end
    end
  endtask

  task automatic test_hold();
    cycle(0, 0, 1, 3'd1, 16'h00FF, 0, 3'd0, 0, 3'd0);
    cycle(0, 0, 0, 3'd0, 16'h0, 1, 3'd1, 0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 3'd1, 16'($urandom), 0, 3'($urandom), 0, 3'd0);
      tests++;
      if ({rdata_a, rhit_a} !== {16'h00FF, 1'b1}) begin
        fails++; $display("FAIL hold cycle=%0d got %h/%b want 00ff/1", i, rdata_a, rhit_a);
      end
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 3'(i), 16'($urandom), 1, 3'(i), 1, 3'(i));
    cycle(1, 0, 1, 3'd4, 16'h5555, 1, 3'd4, 0, 3'd0);
    tests++;
    if ({rdata_a, rhit_a, rdata_b, rhit_b} !== 34'h0) begin
      fails++; $display("FAIL midreset got a=%h/%b b=%h/%b want 0/0", rdata_a, rhit_a, rdata_b, rhit_b);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 3'd0, 16'h0, 1, 3'(i), 1, 3'(i));
      tests++;
      if ({rhit_a, rhit_b} !== 2'b00) begin
        fails++; $display("FAIL midreset_after addr=%0d got hits %b%b want 00", i, rhit_a, rhit_b);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            3'($urandom), 16'($urandom), $urandom_range(0, 3) != 0, 3'($urandom),
            $urandom_range(0, 3) != 0, 3'($urandom));
      tests++;
      if ({rdata_a, rhit_a, rdata_b, rhit_b} !== {ead, eah, ebd, ebh}) begin
        fails++; $display("FAIL random n=%0d got a=%h/%b b=%h/%b want a=%h/%b b=%h/%b",
                          n, rdata_a, rhit_a, rdata_b, rhit_b, ead, eah, ebd, ebh);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m[i] = '0; v[i] = 0; end
    ead = '0; ebd = '0; eah = 0; ebh = 0;
    test_reset();
    test_write_read();
    test_collision();
    test_clear();
    test_hold();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
